// File: rtl/sgmii_pkg.sv
// rtl/sgmii_pkg.sv - shared SGMII word layout constants and tx arbiter state encoding
package sgmii_pkg;

  localparam int SGMII_WORD_W  = 9;
  localparam int SGMII_EOF_BIT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/sgmii_rr_pick.sv
// rtl/sgmii_rr_pick.sv - combinational round-robin picker for up to four requesters
module sgmii_rr_pick #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      last,
  output logic            any,
  output logic [1:0]      pick
);

  logic [3:0] req_pad;

  // Zero-extend so ports at or above NREQ can never be selected.
  assign req_pad = 4'(req);

  // Scan upward from the port after last, wrapping at NREQ; the first requester found wins.
  always_comb begin
    logic [2:0] idx;
    any  = 1'b0;
    pick = last;
    idx  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = {1'b0, last} + 3'(k);
      if (idx >= 3'(NREQ)) begin
        idx = idx - 3'(NREQ);
      end
      if (!any && req_pad[idx[1:0]]) begin
        any  = 1'b1;
        pick = idx[1:0];
      end
    end
  end

endmodule

// File: rtl/sgmii_tx_arb.sv
// rtl/sgmii_tx_arb.sv - frame-atomic round-robin arbiter feeding one SGMII tx FIFO write port
module sgmii_tx_arb
  import sgmii_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IFG  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SGMII_WORD_W*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]              req_valid,
  output logic [NREQ-1:0]              req_ready,
  output logic [SGMII_WORD_W-1:0]      fifo_in,
  output logic                         push,
  input  logic                         full,
  output logic [1:0]                   grant_id,
  output logic                         busy,
  output logic                         frame_done
);

  arb_state_t              state;
  logic [1:0]              last_grant;
  logic [3:0]              gap_cnt;
  logic                    pick_any;
  logic [1:0]              pick_id;
  logic [SGMII_WORD_W-1:0] cur_word;
  logic                    cur_valid;

  sgmii_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req  (req_valid),
    .last (last_grant),
    .any  (pick_any),
    .pick (pick_id)
  );

  assign busy = (state == XFER);

  // Route the granted port's word and valid onto the shared path.
  always_comb begin
    cur_word  = '0;
    cur_valid = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == 2'(i)) begin
        cur_word  = req_data[i*SGMII_WORD_W +: SGMII_WORD_W];
        cur_valid = req_valid[i];
      end
    end
  end

  // Only the granted port is acknowledged, and never while the FIFO is full.
  always_comb begin
    push       = busy & cur_valid & ~full;
    frame_done = push & cur_word[SGMII_EOF_BIT];
    fifo_in    = busy ? cur_word : '0;
    req_ready  = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = push && (grant_id == 2'(i));
    end
  end

  // IDLE picks a port, XFER holds it until its EOF is pushed, GAP spaces out frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= 2'(NREQ - 1);
      gap_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant_id   <= pick_id;
            last_grant <= pick_id;
            state      <= XFER;
          end
        end
        XFER: begin
          if (frame_done) begin
            if (IFG == 0) begin
              state <= IDLE;
            end else begin
              state   <= GAP;
              gap_cnt <= 4'(IFG);
            end
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt - 4'd1;
          if (gap_cnt <= 4'd1) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sgmii_tx_arb.sv
// tb/tb_sgmii_tx_arb.sv - self-checking bench for sgmii_tx_arb with a frame-level reference model
module tb_sgmii_tx_arb;

  localparam int NA = 2;
  localparam int IA = 2;
  localparam int NB = 4;
  localparam int IB = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [9*NA-1:0] data_a;
  logic [NA-1:0]   valid_a, ready_a;
  logic [8:0]      fifo_a;
  logic            push_a, full_a, busy_a, done_a;
  logic [1:0]      gid_a;
  logic [9*NB-1:0] data_b;
  logic [NB-1:0]   valid_b, ready_b;
  logic [8:0]      fifo_b;
  logic            push_b, full_b, busy_b, done_b;
  logic [1:0]      gid_b;

  sgmii_tx_arb #(.NREQ(NA), .IFG(IA)) u_a (
    .clk(clk), .rst(rst), .req_data(data_a), .req_valid(valid_a), .req_ready(ready_a),
    .fifo_in(fifo_a), .push(push_a), .full(full_a), .grant_id(gid_a), .busy(busy_a),
    .frame_done(done_a)
  );

  sgmii_tx_arb #(.NREQ(NB), .IFG(IB)) u_b (
    .clk(clk), .rst(rst), .req_data(data_b), .req_valid(valid_b), .req_ready(ready_b),
    .fifo_in(fifo_b), .push(push_b), .full(full_b), .grant_id(gid_b), .busy(busy_b),
    .frame_done(done_b)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // reference model state: owner = -1 when no frame is in flight, hold = idle cycles still owed
  int nreq [2] = '{NA, NB};
  int ifg  [2] = '{IA, IB};
  int m_owner [2];
  int m_last  [2];
  int m_hold  [2];

  logic [8:0] q [2][4][$];
  bit         rnd;
  bit         rst_drv;
  bit         ffull [2];
  bit         vmask [2][4];
  logic       vin [2][4];
  logic [8:0] din [2][4];
  logic       fin [2];

  logic       o_push [2], o_busy [2], o_done [2];
  logic [8:0] o_fifo [2];
  logic [1:0] o_gid [2];
  logic [3:0] o_ready [2];

  task automatic model_check(input int d);
    int o, p;
    logic e_push;
    logic [8:0] e_fifo;
    logic [3:0] e_ready;
    string t;
    o = m_owner[d];
    e_push = 1'b0;
    e_fifo = '0;
    e_ready = '0;
    if (o >= 0) begin
      e_fifo = din[d][o];
      e_push = vin[d][o] && !fin[d];
      e_ready[o] = e_push;
    end
    t = (d == 0) ? "a" : "b";
    chk($sformatf("%s busy", t), int'(o_busy[d]), int'(o >= 0));
    chk($sformatf("%s push", t), int'(o_push[d]), int'(e_push));
    chk($sformatf("%s fifo_in", t), int'(o_fifo[d]), int'(e_fifo));
    chk($sformatf("%s req_ready", t), int'(o_ready[d]), int'(e_ready));
    chk($sformatf("%s frame_done", t), int'(o_done[d]), int'(e_push && e_fifo[8]));
    if (o >= 0) chk($sformatf("%s grant_id", t), int'(o_gid[d]), o);
    if (e_push) void'(q[d][o].pop_front());
    if (rst) begin
      m_owner[d] = -1;
      m_last[d]  = nreq[d] - 1;
      m_hold[d]  = 0;
    end else if (o >= 0) begin
      if (e_push && e_fifo[8]) begin
        m_owner[d] = -1;
        m_hold[d]  = ifg[d];
      end
    end else if (m_hold[d] > 0) begin
      m_hold[d]--;
    end else begin
      for (int k = 1; k <= nreq[d]; k++) begin
        p = (m_last[d] + k) % nreq[d];
        if (vin[d][p]) begin
          m_owner[d] = p;
          m_last[d]  = p;
          break;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    rst = rst_drv;
    for (int d = 0; d < 2; d++) begin
      fin[d] = rnd ? ($urandom_range(0, 3) == 0) : ffull[d];
      for (int p = 0; p < 4; p++) begin
        vin[d][p] = (p < nreq[d]) && (q[d][p].size() != 0) && vmask[d][p] &&
                    (!rnd || $urandom_range(0, 4) != 0);
        din[d][p] = vin[d][p] ? q[d][p][0] : (rnd ? 9'($urandom) : 9'h0);
      end
    end
    for (int p = 0; p < NA; p++) begin
      data_a[9*p +: 9] = din[0][p];
      valid_a[p] = vin[0][p];
    end
    for (int p = 0; p < NB; p++) begin
      data_b[9*p +: 9] = din[1][p];
      valid_b[p] = vin[1][p];
    end
    full_a = fin[0];
    full_b = fin[1];
    @(negedge clk);
    o_push[0] = push_a;  o_busy[0] = busy_a;  o_done[0] = done_a;
    o_fifo[0] = fifo_a;  o_gid[0]  = gid_a;   o_ready[0] = 4'(ready_a);
    o_push[1] = push_b;  o_busy[1] = busy_b;  o_done[1] = done_b;
    o_fifo[1] = fifo_b;  o_gid[1]  = gid_b;   o_ready[1] = 4'(ready_b);
    model_check(0);
    model_check(1);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  int         exp_push [7] = '{0, 1, 1, 1, 0, 0, 0};
  int         exp_fifo [7] = '{0, 'h011, 'h022, 'h133, 0, 0, 0};
  int         exp_done [7] = '{0, 0, 0, 1, 0, 0, 0};
  int         exp_busy [7] = '{0, 1, 1, 1, 0, 0, 0};
  int         exp_gseq [4] = '{0, 1, 0, 1};
  int         exp_cont [8] = '{'h001, 'h102, 'h011, 'h112, 'h003, 'h104, 'h013, 'h114};
  int         exp_bp   [4] = '{'h021, 'h022, 'h023, 'h124};
  int         gseq [$];
  int         wlog [$];
  int         ndone;
  bit         prev_busy;

  initial begin
    rst = 1'b1;
    rst_drv = 1'b1;
    rnd = 1'b0;
    data_a = '0; valid_a = '0; full_a = 1'b0;
    data_b = '0; valid_b = '0; full_b = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1;
      m_last[d]  = nreq[d] - 1;
      m_hold[d]  = 0;
      ffull[d]   = 1'b0;
      for (int p = 0; p < 4; p++) vmask[d][p] = 1'b1;
    end

    // reset state
    idle(2);
    chk("reset busy", int'(o_busy[0]), 0);
    chk("reset push", int'(o_push[0]), 0);
    chk("reset fifo_in", int'(o_fifo[0]), 0);
    chk("reset grant_id", int'(o_gid[0]), 0);
    chk("reset req_ready", int'(o_ready[0]), 0);
    rst_drv = 1'b0;
    idle(1);

    // single port three-word frame, IFG=2
    q[0][0].push_back(9'h011); q[0][0].push_back(9'h022); q[0][0].push_back(9'h133);
    for (int k = 0; k < 7; k++) begin
      cycle();
      chk($sformatf("single push c%0d", k), int'(o_push[0]), exp_push[k]);
      chk($sformatf("single fifo c%0d", k), int'(o_fifo[0]), exp_fifo[k]);
      chk($sformatf("single done c%0d", k), int'(o_done[0]), exp_done[k]);
      chk($sformatf("single busy c%0d", k), int'(o_busy[0]), exp_busy[k]);
    end

    // contention: two frames on each of two ports, valid from reset
    rst_drv = 1'b1;
    q[0][0].push_back(9'h001); q[0][0].push_back(9'h102);
    q[0][0].push_back(9'h003); q[0][0].push_back(9'h104);
    q[0][1].push_back(9'h011); q[0][1].push_back(9'h112);
    q[0][1].push_back(9'h013); q[0][1].push_back(9'h114);
    cycle();
    rst_drv = 1'b0;
    prev_busy = 1'b0;
    for (int k = 0; k < 30; k++) begin
      cycle();
      if (o_busy[0] && !prev_busy) gseq.push_back(int'(o_gid[0]));
      if (o_push[0]) wlog.push_back(int'(o_fifo[0]));
      prev_busy = o_busy[0];
    end
    chk("contention grants", gseq.size(), 4);
    for (int i = 0; i < 4 && i < gseq.size(); i++) chk($sformatf("contention grant %0d", i), gseq[i], exp_gseq[i]);
    chk("contention words", wlog.size(), 8);
    for (int i = 0; i < 8 && i < wlog.size(); i++) chk($sformatf("contention word %0d", i), wlog[i], exp_cont[i]);

    // backpressure: full high on cycles 2..4 of a four-word frame
    wlog.delete();
    for (int i = 0; i < 4; i++) q[0][0].push_back(9'(exp_bp[i]));
    for (int k = 0; k < 11; k++) begin
      ffull[0] = (k >= 2 && k <= 4);
      cycle();
      if (o_push[0]) wlog.push_back(int'(o_fifo[0]));
      if (k >= 2 && k <= 4) begin
        chk($sformatf("full push c%0d", k), int'(o_push[0]), 0);
        chk($sformatf("full ready c%0d", k), int'(o_ready[0]), 0);
      end
    end
    ffull[0] = 1'b0;
    chk("full words", wlog.size(), 4);
    for (int i = 0; i < 4 && i < wlog.size(); i++) chk($sformatf("full word %0d", i), wlog[i], exp_bp[i]);

    // bubble: granted port 0 idles for three cycles while port 1 waits
    q[0][0].push_back(9'h031); q[0][0].push_back(9'h032);
    q[0][0].push_back(9'h033); q[0][0].push_back(9'h134);
    for (int k = 0; k < 14; k++) begin
      if (k == 1) begin
        q[0][1].push_back(9'h041); q[0][1].push_back(9'h142);
      end
      vmask[0][0] = !(k >= 2 && k <= 4);
      cycle();
      chk($sformatf("bubble ready1 c%0d", k), int'(o_ready[0][1]), int'(k == 11 || k == 12));
      if (k >= 2 && k <= 4) begin
        chk($sformatf("bubble busy c%0d", k), int'(o_busy[0]), 1);
        chk($sformatf("bubble grant c%0d", k), int'(o_gid[0]), 0);
      end
    end
    vmask[0][0] = 1'b1;
    idle(3);

    // IFG=0, single-word frames from all four ports
    ndone = 0;
    for (int p = 0; p < 4; p++) q[1][p].push_back(9'h1AA);
    for (int k = 0; k < 9; k++) begin
      cycle();
      chk($sformatf("ifg0 push c%0d", k), int'(o_push[1]), int'(k % 2 == 1));
      if (k % 2 == 1) chk($sformatf("ifg0 grant c%0d", k), int'(o_gid[1]), (k - 1) / 2);
      if (o_done[1]) ndone++;
    end
    chk("ifg0 frame_done count", ndone, 4);

    // reset after the second word of a frame
    q[0][0].push_back(9'h051); q[0][0].push_back(9'h052);
    q[0][0].push_back(9'h053); q[0][0].push_back(9'h154);
    idle(3);
    rst_drv = 1'b1;
    vmask[0][0] = 1'b0;
    cycle();
    q[0][0].delete();
    q[0][0].push_back(9'h160);
    q[0][1].push_back(9'h170);
    rst_drv = 1'b0;
    vmask[0][0] = 1'b1;
    cycle();
    chk("midrst busy", int'(o_busy[0]), 0);
    chk("midrst push", int'(o_push[0]), 0);
    chk("midrst fifo_in", int'(o_fifo[0]), 0);
    chk("midrst ready", int'(o_ready[0]), 0);
    chk("midrst grant_id", int'(o_gid[0]), 0);
    chk("midrst frame_done", int'(o_done[0]), 0);
    cycle();
    chk("midrst next grant", int'(o_gid[0]), 0);
    chk("midrst next word", int'(o_fifo[0]), 'h160);
    idle(8);

    // randomized traffic, backpressure, bubbles and occasional reset
    rnd = 1'b1;
    for (int n = 0; n < 900; n++) begin
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < nreq[d]; p++) begin
          if (q[d][p].size() == 0 && $urandom_range(0, 5) == 0) begin
            int len;
            len = $urandom_range(1, 5);
            for (int w = 0; w < len; w++) begin
              q[d][p].push_back({(w == len - 1), 8'($urandom)});
            end
          end
        end
      end
      rst_drv = ($urandom_range(0, 199) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
